// File: rtl/spm_wb_ctrl.sv
// Wishbone register front end for the serial-parallel multiplier core.
// Holds operands, sequences start/done handshake and captures the product.
module spm_wb_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic [31:0]        wbs_dat_o,
  output logic               wbs_ack_o,
  output logic [WIDTH-1:0]   mc,
  output logic [WIDTH-1:0]   mp,
  output logic               start,
  input  logic               done,
  input  logic [2*WIDTH-1:0] prod,
  output logic               irq
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARM, BUSY, DRAIN} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0]   mc_r, mp_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [CW-1:0]      cnt;
  logic               ie, done_f, to_f, err;
  logic               busy;
  logic               req, wr_req;
  logic [2:0]         reg_sel;
  logic [31:0]        wmask, rdata;
  logic               go_ok, capture, tmo;
  logic               unused_adr;

  assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

  assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr_req  = req & wbs_we_i;
  assign reg_sel = wbs_adr_i[4:2];
  assign wmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                    {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  assign busy    = (state != IDLE);
  assign go_ok   = wr_req && (reg_sel == 3'd2) && wbs_sel_i[0] && wbs_dat_i[0] && !busy;
  assign capture = (state == BUSY) && done;
  assign tmo     = (state == BUSY) && !done && (cnt == CW'(TIMEOUT - 1));

  assign mc    = mc_r;
  assign mp    = mp_r;
  assign start = (state == ARM) || (state == BUSY);
  assign irq   = done_f & ie;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0: rdata = 32'(mc_r);
      3'd1: rdata = 32'(mp_r);
      3'd2: rdata = {30'd0, ie, 1'b0};
      3'd3: rdata = {28'd0, err, to_f, done_f, busy};
      3'd4: rdata = prod_r[31:0];
      3'd5: rdata = prod_r[63:32];
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (go_ok) state_nx = ARM;
      ARM:   state_nx = BUSY;
      BUSY:  if (done) state_nx = DRAIN;
             else if (tmo) state_nx = IDLE;
      DRAIN: if (!done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (go_ok)          cnt <= '0;
    else if (state == BUSY)  cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      mc_r      <= '0;
      mp_r      <= '0;
      prod_r    <= '0;
      ie        <= 1'b0;
      done_f    <= 1'b0;
      to_f      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
      if (wr_req) begin
        case (reg_sel)
          3'd0: if (busy) err <= 1'b1;
                else mc_r <= WIDTH'((32'(mc_r) & ~wmask) | (wbs_dat_i & wmask));
          3'd1: if (busy) err <= 1'b1;
                else mp_r <= WIDTH'((32'(mp_r) & ~wmask) | (wbs_dat_i & wmask));
          3'd2: if (wbs_sel_i[0]) begin
                  if (wbs_dat_i[0] && busy) err <= 1'b1;
                  else ie <= wbs_dat_i[1];
                end
          3'd3: if (wbs_sel_i[0]) begin
                  if (wbs_dat_i[1]) done_f <= 1'b0;
                  if (wbs_dat_i[2]) to_f   <= 1'b0;
                  if (wbs_dat_i[3]) err    <= 1'b0;
                end
          default: ;
        endcase
      end
      // Later assignments take priority: a capture beats a same-cycle W1C of DONE.
      if (go_ok) begin
        done_f <= 1'b0;
        to_f   <= 1'b0;
      end
      if (capture) begin
        done_f <= 1'b1;
        prod_r <= prod;
      end
      if (tmo) to_f <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spm_wb_ctrl.sv
// Directed bench for spm_wb_ctrl with a simple behavioural multiplier core model.
module tb_spm_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w, dat_r;
  logic        ack;
  logic [31:0] mc, mp;
  logic        start, done, irq;
  logic [63:0] prod;

  logic        done_m, done_force;
  logic [63:0] prod_m, model_prod;
  logic        model_en;
  int unsigned model_delay, mcnt;
  int unsigned n_tests = 0, n_fail = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  assign done = done_m | done_force;
  assign prod = done_force ? 64'hDEAD_BEEF_DEAD_BEEF : prod_m;

  spm_wb_ctrl #(.WIDTH(32), .TIMEOUT(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_dat_o(dat_r), .wbs_ack_o(ack),
    .mc(mc), .mp(mp), .start(start), .done(done), .prod(prod), .irq(irq)
  );

  // Core model: raises done model_delay cycles after start, drops it once start falls.
  always @(posedge clk) begin
    if (!model_en || !start) begin
      done_m <= 1'b0;
      mcnt   <= 0;
    end else if (!done_m) begin
      if (mcnt == model_delay - 1) begin
        done_m <= 1'b1;
        prod_m <= model_prod;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [2:0] r, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {27'd0, r, 2'b00}; dat_w = d; sel = s;
    @(negedge clk);
    check("wr_ack", ack, 1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] r, output logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {27'd0, r, 2'b00}; sel = 4'hF;
    @(negedge clk);
    check("rd_ack", ack, 1);
    d = dat_r;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] r, input logic [31:0] exp);
    logic [31:0] v;
    wb_read(r, v);
    check(tag, v, exp);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    check("done_seen", done, 1);
  endtask

  initial begin
    rst_n = 1'b0; cyc = 0; stb = 0; we = 0; sel = 4'hF; adr = '0; dat_w = '0;
    model_en = 1'b0; model_delay = 40; model_prod = '0; done_force = 1'b0; prod_m = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_start", start, 0);
    check("rst_irq", irq, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) rd_chk("rst_reg", 3'(i), 32'h0);

    // Basic op 7*6
    model_en = 1'b1; model_delay = 40; model_prod = 64'd42;
    wb_write(3'd0, 32'h7, 4'hF);
    wb_write(3'd1, 32'h6, 4'hF);
    wb_write(3'd2, 32'h1, 4'hF);
    check("go_start", start, 1);
    repeat (10) @(negedge clk);
    check("busy_start", start, 1);
    check("busy_nodone", done, 0);
    wait_done();
    repeat (5) @(negedge clk);
    check("after_start", start, 0);
    rd_chk("basic_status", 3'd3, 32'h2);
    rd_chk("basic_lo", 3'd4, 32'h2A);
    rd_chk("basic_hi", 3'd5, 32'h0);
    rd_chk("status_reread", 3'd3, 32'h2);

    // Stale done in IDLE must not capture
    done_force = 1'b1;
    repeat (3) @(negedge clk);
    done_force = 1'b0;
    rd_chk("stale_lo", 3'd4, 32'h2A);
    rd_chk("stale_status", 3'd3, 32'h2);

    // Full scale
    model_delay = 20; model_prod = 64'hFFFF_FFFE_0000_0001;
    wb_write(3'd0, 32'hFFFF_FFFF, 4'hF);
    wb_write(3'd1, 32'hFFFF_FFFF, 4'hF);
    wb_write(3'd2, 32'h1, 4'hF);
    wait_done();
    repeat (5) @(negedge clk);
    rd_chk("full_hi", 3'd5, 32'hFFFF_FFFE);
    rd_chk("full_lo", 3'd4, 32'h0000_0001);

    // Byte lanes and unmapped offsets
    wb_write(3'd0, 32'h0, 4'hF);
    wb_write(3'd0, 32'hAABB_CCDD, 4'b0101);
    rd_chk("bytelane_mc", 3'd0, 32'h00BB_00DD);
    wb_write(3'd6, 32'h1234, 4'hF);
    rd_chk("reg6", 3'd6, 32'h0);
    rd_chk("reg7", 3'd7, 32'h0);

    // Timeout with the core silent
    model_en = 1'b0;
    wb_write(3'd2, 32'h1, 4'hF);
    repeat (100) @(negedge clk);
    rd_chk("to_busy", 3'd3, 32'h1);
    repeat (200) @(negedge clk);
    rd_chk("to_status", 3'd3, 32'h4);
    check("to_start", start, 0);
    wb_write(3'd3, 32'h4, 4'hF);
    rd_chk("to_clear", 3'd3, 32'h0);

    // Busy protection and interrupt
    model_en = 1'b1; model_delay = 30; model_prod = 64'h33;
    wb_write(3'd0, 32'h11, 4'hF);
    wb_write(3'd1, 32'h3, 4'hF);
    wb_write(3'd2, 32'h3, 4'hF);
    check("irq_busy", irq, 0);
    wb_write(3'd0, 32'h55, 4'hF);
    rd_chk("prot_mc", 3'd0, 32'h11);
    check("prot_mc_pin", mc, 32'h11);
    rd_chk("prot_status", 3'd3, 32'h9);
    wait_done();
    repeat (5) @(negedge clk);
    check("irq_set", irq, 1);
    rd_chk("irq_status", 3'd3, 32'hA);
    rd_chk("irq_lo", 3'd4, 32'h33);
    rd_chk("ctrl_ie", 3'd2, 32'h2);
    wb_write(3'd3, 32'h2, 4'hF);
    check("irq_clr", irq, 0);
    rd_chk("err_only", 3'd3, 32'h8);
    wb_write(3'd3, 32'h8, 4'hF);
    rd_chk("all_clr", 3'd3, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
